// File: rtl/control_sequencer.sv
// Control-unit sequencer: FETCH -> EXEC(state 0..3), drives the selected class decoder's control word.
// Optional retire counter/pulse ports when CTRL_SEQ_RETIRE_CNT_EN is defined.
module control_sequencer #(
  parameter logic [32:0] FETCH_CW        = 33'h000000010,
  parameter int          MAX_EXEC_CYCLES = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic          instr_valid,
  input  logic [31:0]   instr_in,
  input  logic [263:0]  cw_bank_in,
  input  logic [4:0]    status_in,
  output logic [32:0]   cw_out,
  output logic [31:0]   instr_out,
  output logic [1:0]    state_out,
  output logic [4:0]    status_out,
  output logic [2:0]    class_out,
  output logic          fetch_phase,
  output logic          fault
`ifdef CTRL_SEQ_RETIRE_CNT_EN
  , output logic        retire_pulse,
  output logic [31:0]   retire_count
`endif
);

  typedef enum logic {FETCH, EXEC} phase_t;

  // Write-type fields suppressed while stalled: RF write, RAM write, PC FS, status load.
  localparam logic [32:0] STALL_MASK = 33'h0_0000_02B4;
  localparam logic [2:0]  CNT_LAST   = 3'(MAX_EXEC_CYCLES - 1);

  phase_t      phase, phase_nxt;
  logic [31:0] ir, ir_nxt;
  logic [1:0]  st, st_nxt;
  logic [4:0]  sr, sr_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        flt, flt_nxt;
  logic [32:0] cw_raw;
  logic [8:0]  bank_base;

  assign bank_base = 9'(ir[28:26]) * 9'd33;

  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= FETCH;
      ir    <= '0;
      st    <= '0;
      sr    <= '0;
      cnt   <= '0;
      flt   <= 1'b0;
    end else begin
      phase <= phase_nxt;
      ir    <= ir_nxt;
      st    <= st_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
      flt   <= flt_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    ir_nxt    = ir;
    st_nxt    = st;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    flt_nxt   = flt;
    cw_raw    = '0;
    case (phase)
      FETCH: begin
        cw_raw = instr_valid ? FETCH_CW : '0;
        if (instr_valid && !stall) begin
          ir_nxt    = instr_in;
          st_nxt    = '0;
          cnt_nxt   = '0;
          phase_nxt = EXEC;
        end
      end
      EXEC: begin
        cw_raw = cw_bank_in[bank_base +: 33];
        if (!stall) begin
          if (cw_raw[2]) sr_nxt = status_in;
          if (cw_raw[1:0] == 2'b00) begin
            phase_nxt = FETCH;
            st_nxt    = '0;
          end else if (cnt == CNT_LAST) begin
            // Watchdog: instruction never reached NS=0 within the budget.
            phase_nxt = FETCH;
            st_nxt    = '0;
            flt_nxt   = 1'b1;
          end else begin
            st_nxt  = cw_raw[1:0];
            cnt_nxt = cnt + 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign cw_out      = stall ? (cw_raw & ~STALL_MASK) : cw_raw;
  assign instr_out   = ir;
  assign state_out   = st;
  assign status_out  = sr;
  assign class_out   = ir[28:26];
  assign fetch_phase = (phase == FETCH);
  assign fault       = flt;

`ifdef CTRL_SEQ_RETIRE_CNT_EN
  logic retire;
  assign retire = (phase == EXEC) && !stall && (cw_raw[1:0] == 2'b00);

  always_ff @(posedge clock) begin
    if (reset) begin
      retire_pulse <= 1'b0;
      retire_count <= '0;
    end else begin
      retire_pulse <= retire;
      if (retire) retire_count <= retire_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven bench for control_sequencer with a scoreboard queue of expected records.
module tb_control_sequencer;
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b1;
  logic          instr_valid = 1'b0;
  logic [31:0]   instr_in = '0;
  logic [263:0]  cw_bank_in = '0;
  logic [4:0]    status_in = '0;
  logic [32:0]   cw_out;
  logic [31:0]   instr_out;
  logic [1:0]    state_out;
  logic [4:0]    status_out;
  logic [2:0]    class_out;
  logic          fetch_phase;
  logic          fault;
`ifdef CTRL_SEQ_RETIRE_CNT_EN
  logic          retire_pulse;
  logic [31:0]   retire_count;
`endif

  control_sequencer dut (
    .clock(clock), .reset(reset), .stall(stall), .instr_valid(instr_valid),
    .instr_in(instr_in), .cw_bank_in(cw_bank_in), .status_in(status_in),
    .cw_out(cw_out), .instr_out(instr_out), .state_out(state_out),
    .status_out(status_out), .class_out(class_out), .fetch_phase(fetch_phase),
    .fault(fault)
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    , .retire_pulse(retire_pulse), .retire_count(retire_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        stall, iv;
    logic [31:0] instr;
    logic [4:0]  st_in;
    logic [2:0]  cls;
    logic [32:0] word;
    logic [32:0] cw;
    logic        fetch;
    logic [1:0]  state;
    logic [4:0]  status;
    logic        fault;
    logic [31:0] ir;
    logic        ret;
  } vec_t;

  localparam int NV = 23;
  localparam logic [32:0] W_A = 33'h1_0000_0200;
  localparam logic [32:0] W_S = 33'h1_0000_03FE;
  localparam logic [31:0] I4  = 32'h9100_0421;
  localparam logic [31:0] I1  = 32'h0400_0000;
  localparam logic [31:0] I2  = 32'h0800_0000;
  localparam logic [31:0] I3  = 32'h0C00_0000;

  vec_t vecs [NV];
  vec_t q [$];
  vec_t e;
  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [263:0] mk_bank(input logic [2:0] cls, input logic [32:0] word);
    logic [263:0] b;
    for (int c = 0; c < 8; c++) begin
      logic [2:0] cc;
      cc = 3'(c);
      b[33*c +: 33] = (cc == cls) ? word : {cc, 30'h2AAA_AAA8};
    end
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; stall = 1'b1; instr_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst fetch_phase", 64'(fetch_phase), 64'd1);
    chk("rst state_out", 64'(state_out), 64'd0);
    chk("rst fault", 64'(fault), 64'd0);
    chk("rst cw_out", 64'(cw_out), 64'd0);
    chk("rst instr_out", 64'(instr_out), 64'd0);
    chk("rst status_out", 64'(status_out), 64'd0);
`ifdef CTRL_SEQ_RETIRE_CNT_EN
    chk("rst retire_count", 64'(retire_count), 64'd0);
    chk("rst retire_pulse", 64'(retire_pulse), 64'd0);
`endif
  endtask

  initial begin
    // stall, iv, instr, st_in, cls, word | cw, fetch, state, status, fault, ir, ret
    vecs[0]  = '{0, 0, 0,  5'h00, 4, W_A,    33'h0,  1, 0, 5'h00, 0, 0,  0};
    vecs[1]  = '{0, 1, I4, 5'h00, 4, W_A,    33'h10, 0, 0, 5'h00, 0, I4, 0};
    vecs[2]  = '{0, 0, 0,  5'h1F, 4, W_A,    W_A,    1, 0, 5'h00, 0, I4, 1};
    vecs[3]  = '{0, 1, I1, 5'h03, 1, 33'h5,  33'h10, 0, 0, 5'h00, 0, I1, 0};
    vecs[4]  = '{0, 0, 0,  5'h0A, 1, 33'h5,  33'h5,  0, 1, 5'h0A, 0, I1, 0};
    vecs[5]  = '{0, 0, 0,  5'h15, 1, 33'h82, 33'h82, 0, 2, 5'h0A, 0, I1, 0};
    vecs[6]  = '{0, 0, 0,  5'h11, 1, 33'h204,33'h204,1, 0, 5'h11, 0, I1, 1};
    vecs[7]  = '{0, 1, I2, 5'h00, 2, 33'h1,  33'h10, 0, 0, 5'h11, 0, I2, 0};
    vecs[8]  = '{0, 0, 0,  5'h00, 2, 33'h1,  33'h1,  0, 1, 5'h11, 0, I2, 0};
    vecs[9]  = '{1, 1, I3, 5'h07, 2, W_S, 33'h1_0000_014A, 0, 1, 5'h11, 0, I2, 0};
    vecs[10] = '{1, 1, I3, 5'h07, 2, W_S, 33'h1_0000_014A, 0, 1, 5'h11, 0, I2, 0};
    vecs[11] = '{1, 1, I3, 5'h07, 2, W_S, 33'h1_0000_014A, 0, 1, 5'h11, 0, I2, 0};
    vecs[12] = '{0, 0, 0,  5'h07, 2, W_S,    W_S,    0, 2, 5'h07, 0, I2, 0};
    vecs[13] = '{0, 0, 0,  5'h00, 2, 33'h0,  33'h0,  1, 0, 5'h07, 0, I2, 1};
    vecs[14] = '{1, 1, I3, 5'h00, 3, 33'h1,  33'h0,  1, 0, 5'h07, 0, I2, 0};
    vecs[15] = '{0, 1, I3, 5'h00, 3, 33'h1,  33'h10, 0, 0, 5'h07, 0, I3, 0};
    vecs[16] = '{0, 0, 0,  5'h02, 3, 33'h1,  33'h1,  0, 1, 5'h07, 0, I3, 0};
    vecs[17] = '{0, 0, 0,  5'h00, 3, 33'h2,  33'h2,  0, 2, 5'h07, 0, I3, 0};
    vecs[18] = '{0, 0, 0,  5'h00, 3, 33'h3,  33'h3,  0, 3, 5'h07, 0, I3, 0};
    vecs[19] = '{0, 0, 0,  5'h1C, 3, 33'h7,  33'h7,  1, 0, 5'h1C, 1, I3, 0};
    vecs[20] = '{0, 0, 0,  5'h00, 3, 33'h7,  33'h0,  1, 0, 5'h1C, 1, I3, 0};
    vecs[21] = '{0, 1, I4, 5'h00, 4, W_A,    33'h10, 0, 0, 5'h1C, 1, I4, 0};
    vecs[22] = '{0, 0, 0,  5'h00, 4, W_A,    W_A,    1, 0, 5'h1C, 1, I4, 1};

    do_reset();

    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      stall       = vecs[i].stall;
      instr_valid = vecs[i].iv;
      instr_in    = vecs[i].instr;
      status_in   = vecs[i].st_in;
      cw_bank_in  = mk_bank(vecs[i].cls, vecs[i].word);
      q.push_back(vecs[i]);
      #1;
      e = q[0];
      chk($sformatf("v%0d cw_out", i), 64'(cw_out), 64'(e.cw));
      @(posedge clock);
      #1;
      e = q.pop_front();
      chk($sformatf("v%0d fetch_phase", i), 64'(fetch_phase), 64'(e.fetch));
      chk($sformatf("v%0d state_out", i), 64'(state_out), 64'(e.state));
      chk($sformatf("v%0d status_out", i), 64'(status_out), 64'(e.status));
      chk($sformatf("v%0d fault", i), 64'(fault), 64'(e.fault));
      chk($sformatf("v%0d instr_out", i), 64'(instr_out), 64'(e.ir));
      chk($sformatf("v%0d class_out", i), 64'(class_out), 64'(e.ir[28:26]));
`ifdef CTRL_SEQ_RETIRE_CNT_EN
      chk($sformatf("v%0d retire_pulse", i), 64'(retire_pulse), 64'(e.ret));
`endif
    end

`ifdef CTRL_SEQ_RETIRE_CNT_EN
    chk("retire_count total", 64'(retire_count), 64'd4);
`endif

    // Fault is sticky until reset, and reset wins over a concurrent stall.
    @(negedge clock);
    stall = 1'b0; instr_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("fault sticky", 64'(fault), 64'd1);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
